// File: rtl/bist_adder_engine.sv
`default_nettype none
// ============================================================================
// Module   : bist_adder_engine
// Brief    : LFSR-driven BIST of a ripple-carry adder with stuck-at fault
//            injection and MISR signature compaction.
// Revision : 1.0 - initial release
// ============================================================================
module bist_adder_engine #(
   parameter int               WIDTH        = 4,
   parameter int               NUM_PATTERNS = 32,
   parameter logic [2*WIDTH:0] LFSR_TAPS    = 9'h110,
   parameter logic [2*WIDTH:0] LFSR_SEED    = 9'h001,
   parameter logic [WIDTH:0]   MISR_POLY    = 5'h05
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             fault_en,
   input  logic [1:0]       fault_cls,
   input  logic [7:0]       fault_idx,
   input  logic             fault_val,
   input  logic [WIDTH:0]   golden_sig,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH:0]   signature,
   output logic [15:0]      pattern_cnt
);

   localparam logic [15:0] c_last_cnt = 16'(NUM_PATTERNS - 1);
   localparam logic [7:0]  c_width    = 8'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_RUN     = 2'd2,
      S_COMPARE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [2*WIDTH:0] r_lfsr;
   logic [WIDTH:0]   r_sig;
   logic [15:0]      r_cnt;
   logic             r_pass;
   logic             r_done;
   logic             r_fen;
   logic [1:0]       r_fcls;
   logic [7:0]       r_fidx;
   logic             r_fval;

   logic             w_hit;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic [WIDTH:0]   w_sig_next;
   logic [2*WIDTH:0] w_lfsr_next;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = S_LOAD;
         S_LOAD:    w_next = S_RUN;
         S_RUN:     if (r_cnt == c_last_cnt) w_next = S_COMPARE;
         S_COMPARE: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Out-of-range indices simply never match a bit position.
   assign w_hit = r_fen && (r_fidx < c_width);

   always_comb begin : p_cut
      logic c;
      logic ai;
      logic bi;
      logic si;
      w_sum  = '0;
      w_cout = 1'b0;
      c      = r_lfsr[2*WIDTH];
      for (int i = 0; i < WIDTH; i++) begin
         ai = r_lfsr[i];
         bi = r_lfsr[WIDTH+i];
         if (w_hit && r_fidx == 8'(i) && r_fcls == 2'd0) ai = r_fval;
         if (w_hit && r_fidx == 8'(i) && r_fcls == 2'd1) bi = r_fval;
         si = ai ^ bi ^ c;
         c  = (ai & bi) | (c & (ai ^ bi));
         if (w_hit && r_fidx == 8'(i) && r_fcls == 2'd2) si = r_fval;
         if (w_hit && r_fidx == 8'(i) && r_fcls == 2'd3) c  = r_fval;
         w_sum[i] = si;
      end
      w_cout = c;
   end

   assign w_sig_next  = {r_sig[WIDTH-1:0], 1'b0}
                      ^ (r_sig[WIDTH] ? MISR_POLY : '0)
                      ^ {w_cout, w_sum};
   assign w_lfsr_next = {r_lfsr[2*WIDTH-1:0], ^(r_lfsr & LFSR_TAPS)};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= LFSR_SEED;
         r_sig  <= '0;
         r_cnt  <= '0;
         r_pass <= 1'b0;
         r_done <= 1'b0;
         r_fen  <= 1'b0;
         r_fcls <= '0;
         r_fidx <= '0;
         r_fval <= 1'b0;
      end else begin
         r_done <= (r_state == S_COMPARE);
         case (r_state)
            S_LOAD: begin
               r_lfsr <= LFSR_SEED;
               r_sig  <= '0;
               r_cnt  <= '0;
               r_pass <= 1'b0;
               r_fen  <= fault_en;
               r_fcls <= fault_cls;
               r_fidx <= fault_idx;
               r_fval <= fault_val;
            end
            S_RUN: begin
               r_sig  <= w_sig_next;
               r_lfsr <= w_lfsr_next;
               r_cnt  <= r_cnt + 16'd1;
            end
            S_COMPARE: r_pass <= (r_sig == golden_sig);
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign pass        = r_pass;
   assign signature   = r_sig;
   assign pattern_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/bist_adder_engine.md
BIST_ADDER_ENGINE -- requirements
Module: bist_adder_engine

Interface
REQ-001 Parameter WIDTH, default 4; adder operand width in bits, range 1-16.
REQ-002 Parameter NUM_PATTERNS, default 32; number of test patterns applied per run, range 1-65535.
REQ-003 Parameter LFSR_TAPS, default 9'h110; feedback mask for the (2*WIDTH+1)-bit LFSR. The default is x^9+x^5+1.
REQ-004 Parameter LFSR_SEED, default 9'h001; LFSR value loaded at run start; must be nonzero.
REQ-005 Parameter MISR_POLY, default 5'h05; feedback mask for the (WIDTH+1)-bit MISR. The default is x^5+x^2+1.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 start  in  1  run request; sampled only in IDLE.
REQ-010 fault_en  in  1  enables stuck-at fault injection.
REQ-011 fault_cls  in  2  fault site class: 0 = a[i], 1 = b[i], 2 = sum[i], 3 = carry-out of bit i.
REQ-012 fault_idx  in  8  bit index i of the fault site.
REQ-013 fault_val  in  1  stuck-at value.
REQ-014 golden_sig  in  WIDTH+1  expected fault-free signature.
REQ-015 busy  out  1  high in LOAD, RUN and COMPARE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 pass  out  1  signature == golden_sig; held until the next LOAD.
REQ-018 signature  out  WIDTH+1  MISR contents.
REQ-019 pattern_cnt  out  16  patterns compacted so far in the current run.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, RUN and COMPARE.
- IDLE -> LOAD when start=1.
- LOAD -> RUN unconditionally.
- RUN -> COMPARE on the edge that compacts pattern NUM_PATTERNS.
- COMPARE -> IDLE unconditionally.
REQ-021 LOAD SHALL perform, in one edge:
- lfsr = LFSR_SEED
- signature = 0
- pattern_cnt = 0
- pass = 0
- latch fault_en, fault_cls, fault_idx and fault_val
REQ-022 After LOAD, fault inputs SHALL have no effect until the next LOAD.
REQ-023 The CUT SHALL be a combinational WIDTH-bit ripple-carry adder with operands:
- a = lfsr[WIDTH-1:0]
- b = lfsr[2*WIDTH-1:WIDTH]
- cin = lfsr[2*WIDTH]
- response resp = {cout, sum[WIDTH-1:0]}
REQ-024 With the latched fault enabled, the selected net SHALL be forced to the latched fault_val.
- a[i] and b[i] are forced before entering the adder.
- A forced carry propagates into bit i+1 or, for i = WIDTH-1, into cout.
REQ-025 A latched fault_idx >= WIDTH SHALL inject no fault.
REQ-026 Each RUN edge SHALL perform:
- signature <= (signature<<1 truncated) ^ (signature[WIDTH] ? MISR_POLY : 0) ^ resp
- lfsr <= {lfsr[2*WIDTH-1:0], ^(lfsr & LFSR_TAPS)}
- pattern_cnt <= pattern_cnt + 1
REQ-027 The COMPARE edge SHALL register pass = (signature == golden_sig) and done = 1.
- done deasserts on the following edge.
REQ-028 Latency: the edge sampling start is edge 0. done SHALL be high exactly after edge NUM_PATTERNS+2, and busy high for NUM_PATTERNS+2 cycles.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 A start coincident with the done pulse SHALL be accepted, because the state is IDLE by then.
REQ-031 Retained outputs: signature, pattern_cnt and pass SHALL hold their values in IDLE until the next LOAD.
REQ-032 The LFSR SHALL advance only in RUN.
REQ-033 pattern_cnt SHALL never exceed NUM_PATTERNS.

Reset
REQ-034 rst SHALL force, on the next edge, overriding all other inputs:
- state = IDLE
- busy, done and pass = 0
- signature and pattern_cnt = 0
- lfsr = LFSR_SEED
- latched fault_en = 0
REQ-035 rst asserted mid-run SHALL abort the run without a done pulse.
- The next run SHALL be bit-identical to a run from cold reset.

Verification
REQ-036 Reset then 10 idle cycles -> busy = done = pass = 0, signature = 0, pattern_cnt = 0 throughout.
REQ-037 Fault-free run with defaults (fault_en = 0, golden_sig = reference-model signature):
- done pulses exactly after edge 34 and busy is high for 34 cycles.
- pattern_cnt = 32, pass = 1.
REQ-038 fault_en = 1, cls = 2, idx = 3, val = 1 (sum[3] stuck-at-1) -> signature equals the model's faulty signature, differs from golden_sig, and pass = 0.
REQ-039 fault_en = 1, cls = 0, idx = 9 (out of range) -> signature equals the fault-free value and pass = 1.
REQ-040 start pulsed at RUN cycle 5, and fault_en toggled at RUN cycle 7:
- Neither event has any effect.
- A rerun after done reproduces an identical signature.
REQ-041 rst asserted at RUN cycle 10:
- busy = 0 after the next edge, with no done pulse.
- A subsequent fault-free run gives pass = 1 and the same signature as REQ-037.
